// File: rtl/sta_engine_param.sv
// Parametrised static-timing-analysis core: serially loads a DAG, relaxes arrival times for the
// longest or shortest START-to-END path, then streams the path delay and node sequence.
module sta_engine_param #(
    parameter int unsigned NODES = 16,
    parameter int unsigned EDGES = 32,
    parameter int unsigned DW    = 4,
    parameter int unsigned OW    = 8,
    parameter int unsigned START = 0,
    parameter int unsigned END   = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    input  logic                     mode,
    input  logic [DW-1:0]            delay,
    input  logic [$clog2(NODES)-1:0] source,
    input  logic [$clog2(NODES)-1:0] destination,
    output logic                     out_valid,
    output logic [OW-1:0]            worst_delay,
    output logic [$clog2(NODES)-1:0] path
);
    localparam int unsigned NW  = $clog2(NODES);
    localparam int unsigned EIW = $clog2(EDGES);
    localparam int unsigned EW  = $clog2(EDGES + 1);
    localparam int unsigned SW  = $clog2(NODES + 1);
    localparam logic [NW-1:0] S_NODE = NW'(START);
    localparam logic [NW-1:0] E_NODE = NW'(END);

    typedef enum logic [2:0] {IDLE, LOAD, RELAX, TRACE, OUT} state_e;

    state_e        state_q, state_d;
    logic          mode_q, mode_d;
    logic [EW-1:0] cnt_q, cnt_d;
    logic [EW-1:0] eidx_q, eidx_d;
    logic [SW-1:0] pass_q, pass_d;
    logic [SW-1:0] sp_q, sp_d;
    logic          chg_q, chg_d;
    logic          first_q, first_d;
    logic          unreach_q, unreach_d;
    logic [NW-1:0] cur_q, cur_d;
    logic          out_valid_q, out_valid_d;
    logic [OW-1:0] worst_q, worst_d;
    logic [NW-1:0] path_q, path_d;

    logic [DW-1:0]    dly_q  [NODES];
    logic [NW-1:0]    src_q  [EDGES];
    logic [NW-1:0]    dst_q  [EDGES];
    logic [OW-1:0]    arr_q  [NODES];
    logic [NW-1:0]    pred_q [NODES];
    logic [NW-1:0]    stk_q  [NODES];
    logic [NODES-1:0] vld_q;

    logic          ld_we_c, init_c, upd_c, push_c, better_c;
    logic [EW-1:0] ld_idx_c;
    logic [NW-1:0] rs_c, rt_c;
    logic [OW-1:0] cand_c;
    logic [SW-1:0] spm1_c;

    // One edge relaxed per cycle; self-loops and edges from unreached nodes never update
    always_comb begin
        rs_c     = src_q[eidx_q[EIW-1:0]];
        rt_c     = dst_q[eidx_q[EIW-1:0]];
        cand_c   = arr_q[rs_c] + OW'(dly_q[rt_c]);
        better_c = mode_q ? (cand_c < arr_q[rt_c]) : (cand_c > arr_q[rt_c]);
        upd_c    = (state_q == RELAX) && (eidx_q != cnt_q) && vld_q[rs_c] &&
                   (rs_c != rt_c) && (!vld_q[rt_c] || better_c);
        spm1_c   = sp_q - SW'(1);
    end

    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        cnt_d       = cnt_q;
        eidx_d      = eidx_q;
        pass_d      = pass_q;
        sp_d        = sp_q;
        chg_d       = chg_q;
        first_d     = first_q;
        unreach_d   = unreach_q;
        cur_d       = cur_q;
        out_valid_d = 1'b0;
        worst_d     = '0;
        path_d      = '0;
        ld_we_c     = 1'b0;
        ld_idx_c    = cnt_q;
        init_c      = 1'b0;
        push_c      = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    state_d  = LOAD;
                    mode_d   = mode;
                    ld_we_c  = 1'b1;
                    ld_idx_c = '0;
                    cnt_d    = EW'(1);
                end
            end
            LOAD: begin
                if (in_valid) begin
                    if (cnt_q < EW'(EDGES)) begin
                        ld_we_c = 1'b1;
                        cnt_d   = cnt_q + EW'(1);
                    end
                end else begin
                    state_d   = RELAX;
                    init_c    = 1'b1;
                    eidx_d    = '0;
                    pass_d    = SW'(1);
                    chg_d     = 1'b0;
                    unreach_d = 1'b0;
                end
            end
            RELAX: begin
                // A full pass with no update means arrivals have converged
                if (eidx_q == cnt_q) begin
                    if (chg_q && (pass_q < SW'(NODES))) begin
                        eidx_d = '0;
                        chg_d  = 1'b0;
                        pass_d = pass_q + SW'(1);
                    end else begin
                        state_d = TRACE;
                        cur_d   = E_NODE;
                        sp_d    = '0;
                    end
                end else begin
                    eidx_d = eidx_q + EW'(1);
                    if (upd_c) begin
                        chg_d = 1'b1;
                    end
                end
            end
            TRACE: begin
                // END is pushed first, so popping yields START..END; unreachable END pushes only itself
                push_c = 1'b1;
                sp_d   = sp_q + SW'(1);
                if (!vld_q[E_NODE] || (cur_q == S_NODE) || (sp_q == SW'(NODES - 1))) begin
                    state_d   = OUT;
                    first_d   = 1'b1;
                    unreach_d = !vld_q[E_NODE];
                end else begin
                    cur_d = pred_q[cur_q];
                end
            end
            OUT: begin
                out_valid_d = 1'b1;
                path_d      = stk_q[spm1_c[NW-1:0]];
                if (first_q) begin
                    worst_d = unreach_q ? {OW{1'b1}} : arr_q[E_NODE];
                end
                first_d = 1'b0;
                sp_d    = spm1_c;
                if (sp_q == SW'(1)) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            mode_q      <= 1'b0;
            cnt_q       <= '0;
            eidx_q      <= '0;
            pass_q      <= '0;
            sp_q        <= '0;
            chg_q       <= 1'b0;
            first_q     <= 1'b0;
            unreach_q   <= 1'b0;
            cur_q       <= '0;
            out_valid_q <= 1'b0;
            worst_q     <= '0;
            path_q      <= '0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            cnt_q       <= cnt_d;
            eidx_q      <= eidx_d;
            pass_q      <= pass_d;
            sp_q        <= sp_d;
            chg_q       <= chg_d;
            first_q     <= first_d;
            unreach_q   <= unreach_d;
            cur_q       <= cur_d;
            out_valid_q <= out_valid_d;
            worst_q     <= worst_d;
            path_q      <= path_d;
        end
    end

    // Graph storage, arrival/predecessor tables and the path stack
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NODES; i++) begin
                dly_q[i]  <= '0;
                arr_q[i]  <= '0;
                pred_q[i] <= '0;
                stk_q[i]  <= '0;
            end
            for (int unsigned j = 0; j < EDGES; j++) begin
                src_q[j] <= '0;
                dst_q[j] <= '0;
            end
            vld_q <= '0;
        end else begin
            if (ld_we_c) begin
                src_q[ld_idx_c[EIW-1:0]] <= source;
                dst_q[ld_idx_c[EIW-1:0]] <= destination;
                if (ld_idx_c < EW'(NODES)) begin
                    dly_q[ld_idx_c[NW-1:0]] <= delay;
                end
            end
            if (init_c) begin
                vld_q         <= '0;
                vld_q[S_NODE] <= 1'b1;
                arr_q[S_NODE] <= OW'(dly_q[S_NODE]);
            end
            if (upd_c) begin
                arr_q[rt_c]  <= cand_c;
                pred_q[rt_c] <= rs_c;
                vld_q[rt_c]  <= 1'b1;
            end
            if (push_c) begin
                stk_q[sp_q[NW-1:0]] <= cur_q;
            end
        end
    end

    assign out_valid   = out_valid_q;
    assign worst_delay = worst_q;
    assign path        = path_q;

endmodule

// File: tb/tb_sta_engine_param.sv
// Directed bench for sta_engine_param: default instance plus an 8-node instance with START=7, END=0.
module tb_sta_engine_param;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic       iv1 = 1'b0, md1 = 1'b0, ov1;
    logic [3:0] dl1 = '0, sr1 = '0, ds1 = '0, pt1;
    logic [7:0] wd1;
    logic       iv6 = 1'b0, md6 = 1'b0, ov6;
    logic [2:0] dl6 = '0, sr6 = '0, ds6 = '0, pt6;
    logic [5:0] wd6;

    sta_engine_param u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(iv1), .mode(md1), .delay(dl1),
        .source(sr1), .destination(ds1), .out_valid(ov1), .worst_delay(wd1), .path(pt1)
    );

    sta_engine_param #(.NODES(8), .EDGES(12), .DW(3), .OW(6), .START(7), .END(0)) u_dut6 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv6), .mode(md6), .delay(dl6),
        .source(sr6), .destination(ds6), .out_valid(ov6), .worst_delay(wd6), .path(pt6)
    );

    int errors = 0;
    int checks = 0;
    int dv[16];
    int sv[32];
    int tv[32];
    int ep[16];
    int elen = 0;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic clear_graph();
        for (int i = 0; i < 16; i++) dv[i] = 0;
        for (int i = 0; i < 32; i++) begin
            sv[i] = 5;
            tv[i] = 6;
        end
    endtask

    task automatic graph1();
        clear_graph();
        sv[0] = 0; tv[0] = 2;
        sv[1] = 2; tv[1] = 3;
        sv[2] = 3; tv[2] = 1;
        dv[0] = 1; dv[2] = 2; dv[3] = 3; dv[1] = 4;
        ep[0] = 0; ep[1] = 2; ep[2] = 3; ep[3] = 1;
        elen = 4;
    endtask

    task automatic send(input int sel, input int m);
        int ne = (sel != 0) ? 12 : 32;
        int nn = (sel != 0) ? 8 : 16;
        for (int i = 0; i < ne; i++) begin
            @(negedge clk);
            if (sel == 0) begin
                iv1 = 1'b1; md1 = m[0];
                dl1 = 4'((i < nn) ? dv[i] : 0);
                sr1 = 4'(sv[i]); ds1 = 4'(tv[i]);
            end else begin
                iv6 = 1'b1; md6 = m[0];
                dl6 = 3'((i < nn) ? dv[i] : 0);
                sr6 = 3'(sv[i]); ds6 = 3'(tv[i]);
            end
        end
        @(negedge clk);
        iv1 = 1'b0; md1 = 1'b0;
        iv6 = 1'b0; md6 = 1'b0;
    endtask

    // Waits (bounded by the latency limit) for out_valid, then checks every reported cycle
    task automatic collect(input int sel, input string name, input int wexp, input bit pulse);
        int n = 0;
        int lim = (sel != 0) ? (12 * 8 + 16 + 8) : (32 * 16 + 32 + 8);
        while (((sel != 0) ? ov6 : ov1) !== 1'b1 && n < lim) begin
            @(negedge clk);
            n++;
        end
        if (n >= lim) begin
            check({name, "_timeout"}, 0, 1);
            return;
        end
        for (int k = 0; k < elen; k++) begin
            check({name, "_valid"}, int'((sel != 0) ? ov6 : ov1), 1);
            check({name, "_path"}, int'((sel != 0) ? pt6 : pt1), ep[k]);
            check({name, "_delay"}, int'((sel != 0) ? wd6 : wd1), (k == 0) ? wexp : 0);
            if (pulse && k == 0) begin
                iv6 = 1'b1; sr6 = 3'd1; ds6 = 3'd2; dl6 = 3'd5;
            end
            @(negedge clk);
            iv6 = 1'b0;
        end
        check({name, "_end"}, int'((sel != 0) ? ov6 : ov1), 0);
    endtask

    initial begin
        int n;
        repeat (3) @(negedge clk);
        check("rst_valid", int'(ov1), 0);
        check("rst_delay", int'(wd1), 0);
        check("rst_path", int'(pt1), 0);
        check("rst_valid6", int'(ov6), 0);
        rst_n = 1'b1;

        // Basic chain
        graph1();
        send(0, 0);
        collect(0, "t1", 10, 1'b0);

        // Longest vs shortest
        clear_graph();
        sv[0] = 0; tv[0] = 2;
        sv[1] = 2; tv[1] = 1;
        sv[2] = 0; tv[2] = 3;
        sv[3] = 3; tv[3] = 4;
        sv[4] = 4; tv[4] = 1;
        dv[0] = 1; dv[1] = 1; dv[2] = 9; dv[3] = 3; dv[4] = 3;
        ep[0] = 0; ep[1] = 2; ep[2] = 1; elen = 3;
        send(0, 0);
        collect(0, "t2_max", 11, 1'b0);
        ep[0] = 0; ep[1] = 3; ep[2] = 4; ep[3] = 1; elen = 4;
        send(0, 1);
        collect(0, "t2_min", 8, 1'b0);

        // Max delays, single edge and full 16-node chain
        clear_graph();
        sv[0] = 0; tv[0] = 1;
        dv[0] = 15; dv[1] = 15;
        ep[0] = 0; ep[1] = 1; elen = 2;
        send(0, 0);
        collect(0, "t3_edge", 30, 1'b0);
        clear_graph();
        ep[0] = 0;
        for (int k = 1; k < 15; k++) ep[k] = k + 1;
        ep[15] = 1;
        elen = 16;
        for (int i = 0; i < 15; i++) begin
            sv[i] = ep[i];
            tv[i] = ep[i + 1];
        end
        for (int i = 0; i < 16; i++) dv[i] = 15;
        send(0, 0);
        collect(0, "t3_chain", 240, 1'b0);

        // Unreachable END, then a normal pattern
        clear_graph();
        sv[0] = 0; tv[0] = 2;
        dv[1] = 3;
        ep[0] = 1; elen = 1;
        send(0, 0);
        collect(0, "t4_unreach", 255, 1'b0);
        graph1();
        send(0, 0);
        collect(0, "t4_after", 10, 1'b0);

        // Reset during RELAX
        send(0, 0);
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("t5_relax_valid", int'(ov1), 0);
        check("t5_relax_delay", int'(wd1), 0);
        check("t5_relax_path", int'(pt1), 0);
        @(negedge clk);
        rst_n = 1'b1;
        send(0, 0);
        collect(0, "t5_post_relax", 10, 1'b0);

        // Reset during second OUT cycle
        send(0, 0);
        n = 0;
        while (ov1 !== 1'b1 && n < 552) begin
            @(negedge clk);
            n++;
        end
        check("t5_out_seen", int'(ov1), 1);
        @(negedge clk);
        check("t5_out_path2", int'(pt1), 2);
        rst_n = 1'b0;
        #1;
        check("t5_out_valid", int'(ov1), 0);
        check("t5_out_path", int'(pt1), 0);
        check("t5_out_delay", int'(wd1), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("t5_out_quiet", int'(ov1), 0);
        send(0, 0);
        collect(0, "t5_post_out", 10, 1'b0);

        // Alternate parameter set with in_valid pulsed during OUT
        clear_graph();
        dv[7] = 7; dv[3] = 7; dv[0] = 7;
        sv[0] = 7; tv[0] = 3;
        sv[1] = 3; tv[1] = 0;
        ep[0] = 7; ep[1] = 3; ep[2] = 0; elen = 3;
        send(1, 0);
        collect(1, "t6", 21, 1'b1);
        repeat (3) @(negedge clk);
        check("t6_idle", int'(ov6), 0);
        send(1, 0);
        collect(1, "t6_again", 21, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
